// File: rtl/dip_pkg.sv
// Shared constants for the debounced input port: register word offsets and bus width.
package dip_pkg;
    localparam int BUS_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RAW     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchroniser, polarity normalisation, hold-time
// debounce counter and a one-cycle delayed copy of the clean value for
// rising-edge detection.
module debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic INVERT          = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic logical,
    output logic stable,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] count;
    logic             stable_d;

    // Synchroniser resets to the inactive pad level so the logical value starts at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= INVERT;
            sync_p1 <= INVERT;
        end else begin
            sync_p0 <= pad;
            sync_p1 <= sync_p0;
        end
    end

    assign logical = sync_p1 ^ INVERT;

    // A change is accepted only after it has held for DEBOUNCE_CYCLES consecutive clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
            if (logical == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= logical;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;
endmodule

// File: rtl/debounced_input_port.sv
// PIO-compatible Avalon-MM slave for debounced switch/pushbutton inputs with
// per-channel rising-edge capture and a maskable level interrupt.
module debounced_input_port
    import dip_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INVERT_MASK     = 'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_raw,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [BUS_W-1:0] writedata,
    output logic [BUS_W-1:0] readdata,
    output logic             irq
);
    logic [WIDTH-1:0] logical;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] w1c;
    logic [BUS_W-1:0] rd_mux;
    logic             wr_en;
    logic             rd_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (INVERT_MASK[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .pad    (in_raw[i]),
            .logical(logical[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // Upper write-data bits have no storage behind them
    if (WIDTH < BUS_W) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[BUS_W-1:WIDTH];
    end

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;
    assign w1c   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: a new rise overrides a same-cycle write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~w1c) | rise;
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_RAW:     rd_mux[WIDTH-1:0] = logical;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            default:      rd_mux[WIDTH-1:0] = edgecapture;
        endcase
    end

    // Registered read data with one-cycle latency; holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);
endmodule

// File: tb/tb_debounced_input_port.sv
// Randomised plus directed bench for debounced_input_port against a window-based reference model.
module tb_debounced_input_port;
    localparam int         W   = 4;
    localparam int         D   = 4;
    localparam logic [3:0] INV = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_raw = 4'hF;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [3:0]  m_s1, m_s2, m_st, m_std, m_mask, m_ec;
    logic [31:0] m_rd;
    logic [3:0]  m_hist[$];

    debounced_input_port #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .INVERT_MASK    (INV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_raw    (in_raw),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a pad value enters the logical view two edges after being driven;
    // the clean value flips once the last D logical samples all disagree with it.
    task automatic model_step();
        logic [3:0] lg, rise, nst, w1c;
        bit all_diff;
        lg = m_s2 ^ INV;
        if (reset) begin
            m_s1 = INV; m_s2 = INV; m_st = '0; m_std = '0;
            m_mask = '0; m_ec = '0; m_rd = '0;
            m_hist.delete();
        end else begin
            rise = m_st & ~m_std;
            m_hist.push_back(lg);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            nst = m_st;
            for (int ch = 0; ch < W; ch++) begin
                if (m_hist.size() == D) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][ch] == m_st[ch]) all_diff = 1'b0;
                    if (all_diff) nst[ch] = ~m_st[ch];
                end
            end
            if (chipselect && read) begin
                case (address)
                    2'd0: m_rd = {28'd0, m_st};
                    2'd1: m_rd = {28'd0, lg};
                    2'd2: m_rd = {28'd0, m_mask};
                    default: m_rd = {28'd0, m_ec};
                endcase
            end
            w1c = (chipselect && write && address == 2'd3) ? writedata[3:0] : 4'd0;
            if (chipselect && write && address == 2'd2) m_mask = writedata[3:0];
            m_ec  = (m_ec & ~w1c) | rise;
            m_std = m_st;
            m_st  = nst;
            m_s2  = m_s1;
            m_s1  = in_raw;
        end
    endtask

    // Apply bus signals for one clock, advance model, then check both outputs.
    task automatic cyc(input logic cs, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
        @(posedge clk);
        model_step();
        #1;
        chk("readdata", readdata, m_rd);
        chk("irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cyc(1'b1, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        cyc(1'b1, 1'b0, 1'b1, a, wd);
    endtask

    initial begin
        bit found;
        // 1: reset with all pads inactive
        reset = 1'b1; in_raw = 4'hF;
        repeat (3) idle();
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        rd_reg(2'd0);
        chk("data_after_rst", readdata, 32'd0);

        // 2: hold channel 1 active
        in_raw = 4'b1101;
        repeat (10) rd_reg(2'd0);
        chk("data_ch1", readdata, 32'h2);
        rd_reg(2'd3);
        chk("ec_ch1", readdata, 32'h2);

        // 3: channel 2 bounces faster than the debounce window
        for (int i = 0; i < 10; i++) begin
            in_raw[2] = ~in_raw[2];
            rd_reg(2'd1);
            rd_reg(2'd1);
        end
        in_raw[2] = 1'b1;
        repeat (4) rd_reg(2'd0);
        chk("data_bounce", readdata & 32'h4, 32'h0);
        rd_reg(2'd3);
        chk("ec_bounce", readdata, 32'h2);

        // 4: mask and clear
        wr_reg(2'd2, 32'hFFFF_FFF2);
        idle();
        chk("irq_masked_on", {31'd0, irq}, 32'd1);
        rd_reg(2'd2);
        chk("mask_readback", readdata, 32'h2);
        wr_reg(2'd3, 32'd0);
        idle();
        chk("irq_w0_keeps", {31'd0, irq}, 32'd1);
        wr_reg(2'd3, 32'd2);
        idle();
        chk("irq_w1c_off", {31'd0, irq}, 32'd0);

        // 5: rise on ch0 in the same clock as a W1C of bit 0
        wr_reg(2'd2, 32'd1);
        in_raw[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_st[0] && !m_std[0]) begin
                wr_reg(2'd3, 32'd1);
                found = 1'b1;
            end else begin
                idle();
            end
        end
        chk("rise_seen", {31'd0, found}, 32'd1);
        rd_reg(2'd3);
        chk("ec_set_wins", readdata & 32'h1, 32'h1);
        chk("irq_set_wins", {31'd0, irq}, 32'd1);

        // 6: reset in the middle of a count on ch3
        in_raw[3] = 1'b0;
        repeat (4) idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("rst_mid_rd", readdata, 32'd0);
        rd_reg(2'd0);
        chk("rst_mid_data", readdata, 32'd0);
        repeat (10) rd_reg(2'd0);
        chk("reaccept_ch3", readdata & 32'h8, 32'h8);
        rd_reg(2'd3);
        chk("reedge_ch3", readdata & 32'h8, 32'h8);

        // random phase
        in_raw = 4'hF;
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] wd;
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 11) == 0) in_raw[b] = ~in_raw[b];
            reset = ($urandom_range(0, 599) == 0);
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) wd[3:0] = 4'd0;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), wd);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
